// File: rtl/fc_stream_feeder_if.sv
// Memory read port and output stream of the FC operand feeder.
// master = feeder side, slave = memory / FC core side.
interface fc_stream_feeder_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) ();
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              dout_valid;
  logic              dout_ready;
  logic [DATA_W-1:0] dout_data;

  modport master (
    output mem_en, mem_addr, dout_valid, dout_data,
    input  mem_rdata, dout_ready
  );

  modport slave (
    input  mem_en, mem_addr, dout_valid, dout_data,
    output mem_rdata, dout_ready
  );
endinterface

// File: rtl/fc_stream_feeder.sv
// FC operand feeder: streams cin inputs, cin*cout weights and optional cout
// biases from a 1-cycle-latency memory through a 2-entry FIFO, with an idle
// cycle between phases.
module fc_stream_feeder #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [10:0]        cin,
  input  logic [10:0]        cout,
  input  logic               has_bias,
  input  logic [ADDR_W-1:0]  in_base,
  input  logic [ADDR_W-1:0]  w_base,
  input  logic [ADDR_W-1:0]  b_base,
  fc_stream_feeder_if.master bus,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    S_IDLE, S_IN, S_GAP1, S_W, S_GAP2, S_B, S_FIN
  } state_e;

  state_e state_q, state_d;

  logic [10:0]       cin_q, cin_d;
  logic [10:0]       cout_q, cout_d;
  logic              has_bias_q, has_bias_d;
  logic [ADDR_W-1:0] w_base_q, w_base_d;
  logic [ADDR_W-1:0] b_base_q, b_base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [21:0]       total_q, total_d;
  logic [21:0]       cnt_q, cnt_d;
  logic              inflight_q, inflight_d;
  logic [DATA_W-1:0] fifo_q [2];
  logic [DATA_W-1:0] fifo_d [2];
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        count_q, count_d;

  logic        in_phase;
  logic        left;
  logic        pop;
  logic        issue;
  logic        drained;
  logic [21:0] phase_len;
  logic [2:0]  occ;

  // Read-issue decision; drained looks through this cycle's pop so the
  // phase ends right after its last transfer.
  always_comb begin
    phase_len = '0;
    in_phase  = (state_q == S_IN) || (state_q == S_W) || (state_q == S_B);
    case (state_q)
      S_IN:    phase_len = {11'd0, cin_q};
      S_W:     phase_len = total_q;
      S_B:     phase_len = {11'd0, cout_q};
      default: phase_len = '0;
    endcase
    left    = in_phase && (cnt_q != phase_len);
    pop     = (count_q != 2'd0) && bus.dout_ready;
    occ     = 3'(count_q) + 3'(inflight_q) - 3'(pop);
    issue   = left && (occ < 3'd2);
    drained = in_phase && !left && (occ == 3'd0);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state sequencing through the three phases
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (cin == '0 || cout == '0) ? S_FIN : S_IN;
      S_IN:    if (drained) state_d = S_GAP1;
      S_GAP1:  state_d = S_W;
      S_W:     if (drained) state_d = has_bias_q ? S_GAP2 : S_FIN;
      S_GAP2:  state_d = S_B;
      S_B:     if (drained) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Config latch, address/element counters and FIFO bookkeeping
  always_comb begin
    cin_d      = cin_q;
    cout_d     = cout_q;
    has_bias_d = has_bias_q;
    w_base_d   = w_base_q;
    b_base_d   = b_base_q;
    total_d    = total_q;
    cnt_d      = cnt_q + 22'(issue);
    addr_d     = addr_q + ADDR_W'(issue);
    if (state_q == S_IDLE && start) begin
      cin_d      = cin;
      cout_d     = cout;
      has_bias_d = has_bias;
      w_base_d   = w_base;
      b_base_d   = b_base;
      total_d    = 22'(cin) * 22'(cout);
      addr_d     = in_base;
      cnt_d      = '0;
    end
    if (state_q == S_GAP1) begin
      addr_d = w_base_q;
      cnt_d  = '0;
    end
    if (state_q == S_GAP2) begin
      addr_d = b_base_q;
      cnt_d  = '0;
    end
    inflight_d = issue;
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (inflight_q) begin
      fifo_d[wr_ptr_q] = bus.mem_rdata;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + 2'(inflight_q) - 2'(pop);
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cin_q      <= '0;
      cout_q     <= '0;
      has_bias_q <= 1'b0;
      w_base_q   <= '0;
      b_base_q   <= '0;
      addr_q     <= '0;
      total_q    <= '0;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      fifo_q     <= '{default: '0};
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= '0;
    end else begin
      cin_q      <= cin_d;
      cout_q     <= cout_d;
      has_bias_q <= has_bias_d;
      w_base_q   <= w_base_d;
      b_base_q   <= b_base_d;
      addr_q     <= addr_d;
      total_q    <= total_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      fifo_q     <= fifo_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Outputs
  always_comb begin
    bus.mem_en     = issue;
    bus.mem_addr   = addr_q;
    bus.dout_valid = (count_q != 2'd0);
    bus.dout_data  = fifo_q[rd_ptr_q];
    busy           = (state_q != S_IDLE);
    done           = (state_q == S_FIN);
  end

endmodule

// File: tb/tb_fc_stream_feeder.sv
// Bench for fc_stream_feeder: memory returns data == address; the model is
// the expected element list built from the layer shape.
module tb_fc_stream_feeder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [10:0] cin = '0;
  logic [10:0] cout = '0;
  logic        has_bias = 1'b0;
  logic [15:0] in_base = '0;
  logic [15:0] w_base = '0;
  logic [15:0] b_base = '0;
  logic        busy;
  logic        done;

  fc_stream_feeder_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  fc_stream_feeder #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .cin(cin), .cout(cout),
    .has_bias(has_bias), .in_base(in_base), .w_base(w_base), .b_base(b_base),
    .bus(bus), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Memory: contents equal address, one cycle read latency
  always @(posedge clk) if (bus.mem_en) bus.mem_rdata <= bus.mem_addr;

  typedef enum int {CMD_ARM, CMD_RST, CMD_END} cmd_e;

  // Written only by the stimulus process
  cmd_e        cmd = CMD_ARM;
  int          cmd_id = 0;
  bit          chk_en = 1'b0;
  bit          rnd_mode = 1'b0;
  int          exp_dones = 1;
  int          lit_len = 0;
  logic [15:0] exp_q[$];
  bit          exp_end_q[$];
  int          lit_pos[$];
  logic [15:0] lit_val[$];

  // Owned by the compare process
  int          checks = 0;
  int          failures = 0;
  int          seen_id = 0;
  int          rd_idx = 0;
  int          xf_idx = 0;
  int          done_cnt = 0;
  bit          p_stall = 1'b0;
  bit          p_end = 1'b0;
  bit          p_final = 1'b0;
  bit          m_busy = 1'b0;
  logic [15:0] p_data = '0;
  logic [15:0] log_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: command handling plus per-cycle checks against the model
  always @(negedge clk) begin
    logic xfer, accept, nf, npe;
    if (cmd_id != seen_id) begin
      seen_id = cmd_id;
      case (cmd)
        CMD_ARM: begin
          rd_idx = 0; xf_idx = 0; done_cnt = 0;
          p_stall = 0; p_end = 0; p_final = 0; m_busy = 0; p_data = '0;
          log_q.delete();
        end
        CMD_RST: begin
          chk("rst_mem_en", bus.mem_en, 0);
          chk("rst_mem_addr", bus.mem_addr, 0);
          chk("rst_dout_valid", bus.dout_valid, 0);
          chk("rst_dout_data", bus.dout_data, 0);
          chk("rst_busy", busy, 0);
          chk("rst_done", done, 0);
        end
        CMD_END: begin
          chk("n_xfer", xf_idx, exp_q.size());
          chk("n_read", rd_idx, exp_q.size());
          chk("n_done", done_cnt, exp_dones);
          chk("lit_len", log_q.size(), lit_len);
          foreach (lit_pos[i]) begin
            if (lit_pos[i] < log_q.size()) chk("lit_data", log_q[lit_pos[i]], lit_val[i]);
            else chk("lit_missing", log_q.size(), lit_pos[i] + 1);
          end
        end
        default: ;
      endcase
    end
    if (chk_en) begin
      xfer = bus.dout_valid && bus.dout_ready;
      if (p_stall) begin
        chk("stall_valid", bus.dout_valid, 1);
        chk("stall_data", bus.dout_data, p_data);
      end
      if (p_end) chk("phase_gap", bus.dout_valid, 0);
      chk("done", done, p_final);
      chk("busy", busy, m_busy);
      chk("outstanding", (rd_idx - xf_idx) <= 2, 1);
      if (bus.mem_en) begin
        chk("read_in_range", rd_idx < exp_q.size(), 1);
        if (rd_idx < exp_q.size()) chk("read_addr", bus.mem_addr, exp_q[rd_idx]);
        rd_idx++;
      end
      nf = 1'b0;
      npe = 1'b0;
      if (xfer) begin
        chk("xfer_in_range", xf_idx < exp_q.size(), 1);
        if (xf_idx < exp_q.size()) begin
          chk("data", bus.dout_data, exp_q[xf_idx]);
          npe = exp_end_q[xf_idx];
          nf = (xf_idx == exp_q.size() - 1);
        end
        log_q.push_back(bus.dout_data);
        xf_idx++;
      end
      if (done) done_cnt++;
      accept = start && !m_busy;
      if (accept && exp_q.size() == 0) nf = 1'b1;
      if (accept) m_busy = 1'b1;
      else if (p_final) m_busy = 1'b0;
      p_final = nf;
      p_end   = npe;
      p_stall = bus.dout_valid && !bus.dout_ready;
      p_data  = bus.dout_data;
    end
  end

  // Sink backpressure
  initial begin
    bus.dout_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.dout_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input cmd_e c);
    cmd = c;
    cmd_id++;
    step();
  endtask

  // Expected stream: inputs, weights (output-major, w_base + o*cin + i), biases
  task automatic build(input int c_in, input int c_out, input bit hb,
                       input logic [15:0] ib, input logic [15:0] wb, input logic [15:0] bb);
    logic [15:0] a;
    exp_q.delete();
    exp_end_q.delete();
    if (c_in != 0 && c_out != 0) begin
      for (int i = 0; i < c_in; i++) begin
        a = ib + 16'(i);
        exp_q.push_back(a);
        exp_end_q.push_back(i == c_in - 1);
      end
      for (int o = 0; o < c_out; o++) begin
        for (int i = 0; i < c_in; i++) begin
          a = wb + 16'(o * c_in + i);
          exp_q.push_back(a);
          exp_end_q.push_back(o == c_out - 1 && i == c_in - 1);
        end
      end
      if (hb) begin
        for (int b = 0; b < c_out; b++) begin
          a = bb + 16'(b);
          exp_q.push_back(a);
          exp_end_q.push_back(b == c_out - 1);
        end
      end
    end
  endtask

  task automatic launch(input int c_in, input int c_out, input bit hb,
                        input logic [15:0] ib, input logic [15:0] wb, input logic [15:0] bb,
                        input bit hold2);
    build(c_in, c_out, hb, ib, wb, bb);
    exp_dones = 1;
    issue(CMD_ARM);
    chk_en = 1'b1;
    cin = 11'(c_in); cout = 11'(c_out); has_bias = hb;
    in_base = ib; w_base = wb; b_base = bb;
    start = 1'b1;
    step();
    start = hold2;
    cin = 11'h7ff; cout = 11'h7ff; has_bias = ~hb;
    in_base = 16'hdead; w_base = 16'hbeef; b_base = 16'hcafe;
    step();
    start = 1'b0;
    if (exp_q.size() >= 8) begin
      step();
      start = 1'b1;
      step();
      start = 1'b0;
    end
  endtask

  task automatic finish_test();
    for (int n = 0; n < 3000 && done_cnt == 0; n++) step();
    repeat (3) step();
    issue(CMD_END);
    chk_en = 1'b0;
  endtask

  task automatic lits_base(input bit hb);
    lit_pos = '{0, 2, 3, 8};
    lit_val = '{16'h0010, 16'h0012, 16'h0020, 16'h0025};
    if (hb) begin
      lit_pos.push_back(9);  lit_val.push_back(16'h0040);
      lit_pos.push_back(10); lit_val.push_back(16'h0041);
      lit_len = 11;
    end else begin
      lit_len = 9;
    end
  endtask

  initial begin
    repeat (3) step();
    issue(CMD_RST);
    rst = 1'b0;

    lits_base(1'b1);
    launch(3, 2, 1'b1, 16'h0010, 16'h0020, 16'h0040, 1'b0);
    finish_test();

    lits_base(1'b0);
    launch(3, 2, 1'b0, 16'h0010, 16'h0020, 16'h0040, 1'b0);
    finish_test();

    rnd_mode = 1'b1;
    lits_base(1'b1);
    launch(3, 2, 1'b1, 16'h0010, 16'h0020, 16'h0040, 1'b0);
    finish_test();

    lit_pos = '{4, 15, 18};
    lit_val = '{16'h0200, 16'h020b, 16'h0302};
    lit_len = 19;
    launch(4, 3, 1'b1, 16'h0100, 16'h0200, 16'h0300, 1'b0);
    finish_test();

    lit_pos = '{1, 2, 5, 7};
    lit_val = '{16'h0000, 16'hfffe, 16'h0001, 16'h0006};
    lit_len = 8;
    launch(2, 2, 1'b1, 16'hffff, 16'hfffe, 16'h0005, 1'b0);
    finish_test();
    rnd_mode = 1'b0;

    // Empty layer; start held into the FIN cycle must be ignored
    lit_pos.delete(); lit_val.delete(); lit_len = 0;
    launch(0, 5, 1'b1, 16'h0010, 16'h0020, 16'h0040, 1'b1);
    finish_test();

    // Abort during the weight phase, then replay
    launch(3, 2, 1'b1, 16'h0010, 16'h0020, 16'h0040, 1'b0);
    for (int n = 0; n < 500 && xf_idx < 8; n++) step();
    rst = 1'b1;
    chk_en = 1'b0;
    step();
    rst = 1'b0;
    issue(CMD_RST);
    build(0, 0, 1'b0, 16'h0, 16'h0, 16'h0);
    exp_dones = 0;
    lit_pos.delete(); lit_val.delete(); lit_len = 0;
    issue(CMD_ARM);
    chk_en = 1'b1;
    repeat (6) step();
    issue(CMD_END);
    chk_en = 1'b0;

    lits_base(1'b1);
    launch(3, 2, 1'b1, 16'h0010, 16'h0020, 16'h0040, 1'b0);
    finish_test();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
